// File: rtl/load_store_unit_if.sv
// Core-request, response and memory-port bundle for the load/store unit.
// Slave is the unit side; master is the core/memory side.
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  localparam int NBYTES = XLEN / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [XLEN-1:0]       req_addr;
  logic [XLEN-1:0]       req_wdata;
  logic                  stall;
  logic                  resp_valid;
  logic [XLEN-1:0]       resp_rdata;
  logic                  resp_misaligned;
  logic                  mem_en;
  logic [XLEN-1:0]       mem_addr;
  logic [NBYTES-1:0]     mem_we;
  logic [8*NBYTES-1:0]   mem_data_in;
  logic [8*NBYTES-1:0]   mem_data_out;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
    output req_ready, stall, resp_valid, resp_rdata, resp_misaligned,
           mem_en, mem_addr, mem_we, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
    input  req_ready, stall, resp_valid, resp_rdata, resp_misaligned,
           mem_en, mem_addr, mem_we, mem_data_in
  );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian load/store unit: IDLE/WAIT/RESP sequencer between a core request
// port and a fixed-latency byte-lane memory. Lane 0 is the most significant byte.
module load_store_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  load_store_unit_if.slave   bus
);
  localparam int NBYTES = XLEN / 8;
  localparam int OFF_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     lat_cnt;
  logic                 misaligned;
  logic                 resp_vld;

  logic [1:0]           size_p1;
  logic                 signed_p1;
  logic                 write_p1;
  logic [OFF_W-1:0]     off_p1;
  logic                 mis_p1;
  logic                 mem_en_p1;
  logic [XLEN-1:0]      mem_addr_p1;
  logic [NBYTES-1:0]    mem_we_p1;
  logic [XLEN-1:0]      mem_data_p1;
  logic [XLEN-1:0]      rdata_p2;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [XLEN-1:0] addr);
    int nb;
    nb = 1 << size;
    return (nb > NBYTES) || ((addr & XLEN'(nb - 1)) != '0);
  endfunction

  // Write-enable bit for lane k sits at position NBYTES-1-k so lane 0 is the MSB.
  function automatic logic [NBYTES-1:0] lane_we(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [NBYTES-1:0] we;
    int nb;
    we = '0;
    nb = 1 << size;
    for (int i = 0; i < NBYTES; i++)
      if (i >= int'(off) && i < int'(off) + nb) we[NBYTES-1-i] = 1'b1;
    return we;
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size, input logic [OFF_W-1:0] off,
                                                  input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] d;
    int nb;
    d  = '0;
    nb = 1 << size;
    if (nb <= NBYTES)
      for (int i = 0; i < NBYTES; i++)
        if (i >= int'(off) && i < int'(off) + nb)
          d[8*(NBYTES-1-i) +: 8] = wdata[8*(nb-1-(i-int'(off))) +: 8];
    return d;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [1:0] size, input logic [OFF_W-1:0] off,
                                                  input logic sgn, input logic [XLEN-1:0] mdata);
    logic [XLEN-1:0] raw;
    logic            fill;
    int nb;
    raw = '0;
    nb  = 1 << size;
    if (nb <= NBYTES) begin
      for (int i = 0; i < NBYTES; i++)
        if (i >= int'(off) && i < int'(off) + nb)
          raw[8*(nb-1-(i-int'(off))) +: 8] = mdata[8*(NBYTES-1-i) +: 8];
      fill = sgn & raw[8*nb-1];
      for (int b = 0; b < XLEN; b++)
        if (b >= 8*nb) raw[b] = fill;
    end
    return raw;
  endfunction

  assign misaligned = is_misaligned(bus.req_size, bus.req_addr);

  always_ff @(posedge clk) begin
    if (rst_b) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.stall     = 1'b0;
    resp_vld      = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.stall     = bus.req_valid;
        if (bus.req_valid) state_nxt = misaligned ? RESP : WAIT;
      end
      WAIT: begin
        bus.stall = 1'b1;
        if (lat_cnt <= CNT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        // A reset arriving in RESP swallows the completion pulse.
        resp_vld  = !rst_b;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      lat_cnt     <= '0;
      size_p1     <= '0;
      signed_p1   <= 1'b0;
      write_p1    <= 1'b0;
      off_p1      <= '0;
      mis_p1      <= 1'b0;
      mem_en_p1   <= 1'b0;
      mem_addr_p1 <= '0;
      mem_we_p1   <= '0;
      mem_data_p1 <= '0;
      rdata_p2    <= '0;
    end else begin
      case (state)
        // Stage 1: capture the request and launch the memory access.
        IDLE: if (bus.req_valid) begin
          size_p1   <= bus.req_size;
          signed_p1 <= bus.req_signed;
          write_p1  <= bus.req_write;
          off_p1    <= bus.req_addr[OFF_W-1:0];
          mis_p1    <= misaligned;
          rdata_p2  <= '0;
          if (!misaligned) begin
            lat_cnt     <= CNT_W'(MEM_LATENCY);
            mem_en_p1   <= 1'b1;
            mem_addr_p1 <= bus.req_addr & ~XLEN'(NBYTES - 1);
            mem_we_p1   <= bus.req_write ? lane_we(bus.req_size, bus.req_addr[OFF_W-1:0]) : '0;
            mem_data_p1 <= bus.req_write ? store_lanes(bus.req_size, bus.req_addr[OFF_W-1:0],
                                                       bus.req_wdata) : '0;
          end
        end
        // Stage 2: count down the latency and sample the returned lanes on the last WAIT edge.
        WAIT: begin
          mem_en_p1 <= 1'b0;
          lat_cnt   <= lat_cnt - CNT_W'(1);
          if (lat_cnt <= CNT_W'(1))
            rdata_p2 <= write_p1 ? '0 : load_extend(size_p1, off_p1, signed_p1, bus.mem_data_out);
        end
        RESP: begin
          lat_cnt     <= '0;
          mis_p1      <= 1'b0;
          mem_en_p1   <= 1'b0;
          mem_addr_p1 <= '0;
          mem_we_p1   <= '0;
          mem_data_p1 <= '0;
          rdata_p2    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid      = resp_vld;
  assign bus.resp_rdata      = resp_vld ? rdata_p2 : '0;
  assign bus.resp_misaligned = resp_vld & mis_p1;
  assign bus.mem_en          = mem_en_p1;
  assign bus.mem_addr        = mem_addr_p1;
  assign bus.mem_we          = mem_we_p1;
  assign bus.mem_data_in     = mem_data_p1;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; SHALL be a multiple of 8, 32 or 64.
REQ-002 Parameter MEM_LATENCY, default 2, number of WAIT cycles per memory access; SHALL be >= 1.
REQ-003 Derived NBYTES = XLEN/8, the number of memory byte lanes; lane 0 SHALL be the most significant byte (big-endian).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_b  in  1  reset, synchronous and active-high.
REQ-006 req_valid  in  1  core requests an access.
REQ-007 req_ready  out  1  unit can accept a request this cycle.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  access size is 2^req_size bytes.
REQ-010 req_signed  in  1  1 = sign-extend load data, 0 = zero-extend.
REQ-011 req_addr  in  XLEN  byte address.
REQ-012 req_wdata  in  XLEN  store data, right-aligned.
REQ-013 stall  out  1  freezes PC/pipeline while the access is outstanding.
REQ-014 resp_valid  out  1  one-cycle completion pulse.
REQ-015 resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
REQ-016 resp_misaligned  out  1  access faulted; qualified by resp_valid.
REQ-017 mem_en  out  1  memory access strobe.
REQ-018 mem_addr  out  XLEN  address aligned down to NBYTES.
REQ-019 mem_we  out  NBYTES  per-lane write enable.
REQ-020 mem_data_in  out  8 x NBYTES  byte lanes driven to memory.
REQ-021 mem_data_out  in  8 x NBYTES  byte lanes returned from memory.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid=1 in IDLE; request fields SHALL be captured on acceptance and ignored at all other times.
REQ-024 A request SHALL be misaligned when req_addr mod 2^req_size != 0, or when 2^req_size > NBYTES.
REQ-025 On acceptance of a misaligned request, the FSM SHALL go IDLE->RESP with no mem_en and no mem_we.
REQ-026 On acceptance of an aligned request, the FSM SHALL go IDLE->WAIT and load a latency counter with MEM_LATENCY.
REQ-027 Timing for an aligned request, with the accept cycle as cycle 0:
- mem_en SHALL be 1 for cycle 1 only;
- mem_addr, mem_we and mem_data_in SHALL be registered and held stable from cycle 1 until the unit returns to IDLE;
- WAIT SHALL last cycles 1..MEM_LATENCY;
- mem_data_out SHALL be sampled at the edge ending cycle MEM_LATENCY;
- RESP SHALL occur in cycle MEM_LATENCY+1.
REQ-028 RESP SHALL last exactly one cycle, with resp_valid=1, then return to IDLE; a new request SHALL be acceptable in the following cycle.
REQ-029 stall SHALL be 1 when (IDLE and req_valid=1) or when in WAIT, and 0 otherwise, including in RESP.
REQ-030 Store lane mapping, with offset o = req_addr mod NBYTES:
- a byte store SHALL place req_wdata[7:0] on lane o;
- a halfword store SHALL place req_wdata[15:8] on lane o and req_wdata[7:0] on lane o+1;
- a full-width store SHALL use all lanes, with the MSB on lane 0;
- mem_we SHALL be set only for the written lanes, and unwritten lanes SHALL be driven 0.
REQ-031 Load data SHALL be assembled from the same lanes as REQ-030, then extended to XLEN bits according to req_signed.
REQ-032 For a load, mem_we SHALL be all zero.
REQ-033 resp_rdata and resp_misaligned SHALL hold their value only while resp_valid=1 and SHALL be 0 otherwise.
REQ-034 Address arithmetic SHALL be unsigned; mem_addr SHALL be req_addr with its low log2(NBYTES) bits cleared, with no wrap check.

Reset
REQ-035 When rst_b=1 at a clock edge, the unit SHALL enter IDLE and drive the following outputs from the next cycle:
- mem_en, mem_we, mem_addr, mem_data_in, resp_valid, resp_rdata and resp_misaligned SHALL be 0;
- req_ready SHALL be 1;
- stall SHALL equal req_valid.
REQ-036 A reset during WAIT or RESP SHALL abort the access with no resp_valid pulse; any mem_en already issued SHALL NOT be retracted.
REQ-037 The latency counter SHALL be 0 after reset.

Verification
REQ-038 Word store then load (XLEN=32, MEM_LATENCY=2):
- stimulus: store at 0x100 of 0xDEADBEEF, then a word load from 0x100;
- required: the store drives mem_we=4'b1111 with lanes DE,AD,BE,EF, and the load gives resp_rdata=0xDEADBEEF in cycle 3 with stall high in cycles 0-2.
REQ-039 Signed byte load:
- stimulus: memory holds 0x80 on lane 2; signed byte load from 0x102;
- required: resp_rdata=0xFFFFFF80; the same load with req_signed=0 gives 0x00000080.
REQ-040 Halfword store at offset 2:
- stimulus: store of 0x1234 to 0x206;
- required: mem_addr=0x204, mem_we=4'b0011, lane2=0x12, lane3=0x34.
REQ-041 Misaligned accesses:
- stimulus: word load from 0x101, and separately req_size=3 at XLEN=32;
- required: resp_valid with resp_misaligned=1 in cycle 1 and mem_en never asserted.
REQ-042 Back-to-back requests:
- stimulus: req_valid held high for two requests;
- required: the second is accepted in the cycle after RESP, and req_valid during WAIT is ignored.
REQ-043 Reset during WAIT:
- stimulus: rst_b=1 in cycle 1 with MEM_LATENCY=3;
- required: IDLE next cycle, no resp_valid, all mem outputs 0; the next request completes normally.
